// File: rtl/btn_debounce.sv
// Multi-channel push-button debouncer with optional auto-repeat.
//
// Each raw button bit is synchronised by a private 2-flop chain and then
// filtered by its own counter. A level change is accepted only after the
// synchronised input has differed from the current debounced level for
// DEBOUNCE_CYCLES consecutive clocks. Any reversion restarts the count.
//
// Optional feature macro: BTN_AUTOREPEAT_EN. When defined, a held button
// produces extra press pulses REPEAT_DELAY cycles after the initial press and
// then every REPEAT_PERIOD cycles until release. When undefined no repeat
// logic exists and the REPEAT_* parameters are ignored.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous reset, active low
//   btn_i          raw asynchronous button levels, active high
//   btn_level_o    debounced level (registered)
//   btn_press_o    one-cycle pulse per accepted press / auto-repeat (registered)
//   btn_release_o  one-cycle pulse per accepted release (registered)

module btn_debounce #(
  parameter int unsigned N_BTN           = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_i,
  output logic [N_BTN-1:0] btn_level_o,
  output logic [N_BTN-1:0] btn_press_o,
  output logic [N_BTN-1:0] btn_release_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0]           sync1_q, sync2_q;
  logic [N_BTN-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [N_BTN-1:0]           level_q, level_d;
  logic [N_BTN-1:0]           press_q, press_d;
  logic [N_BTN-1:0]           release_q, release_d;
  logic [N_BTN-1:0]           toggle;

  // Debounce counters: count while the synchronised input disagrees with the
  // accepted level; agreement at any point discards the partial count.
  always_comb begin
    cnt_d  = cnt_q;
    toggle = '0;
    for (int i = 0; i < int'(N_BTN); i++) begin
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntLast) begin
        cnt_d[i]  = '0;
        toggle[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
    end
    level_d   = level_q ^ toggle;
    release_d = toggle & level_q;
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RepW   = $clog2(RepMax + 1);
  localparam logic [RepW-1:0] DelayLast  = RepW'(REPEAT_DELAY - 1);
  localparam logic [RepW-1:0] PeriodLast = RepW'(REPEAT_PERIOD - 1);

  logic [N_BTN-1:0][RepW-1:0] rep_q, rep_d;
  // Set until the first repeat pulse of a hold: selects delay vs period limit.
  logic [N_BTN-1:0]           first_q, first_d;
  logic [N_BTN-1:0]           rep_pulse;

  // A toggle on this edge is either the initial press or a release; in both
  // cases the repeat counter restarts and no repeat pulse may fire.
  always_comb begin
    rep_d     = rep_q;
    first_d   = first_q;
    rep_pulse = '0;
    for (int i = 0; i < int'(N_BTN); i++) begin
      if (!level_q[i] || toggle[i]) begin
        rep_d[i]   = '0;
        first_d[i] = 1'b1;
      end else if (rep_q[i] == (first_q[i] ? DelayLast : PeriodLast)) begin
        rep_d[i]     = '0;
        first_d[i]   = 1'b0;
        rep_pulse[i] = 1'b1;
      end else begin
        rep_d[i] = rep_q[i] + RepW'(1);
      end
    end
    press_d = (toggle & ~level_q) | rep_pulse;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_q   <= '0;
      first_q <= '1;
    end else begin
      rep_q   <= rep_d;
      first_q <= first_d;
    end
  end
`else
  assign press_d = toggle & ~level_q;

  // The repeat parameters carry no hardware in this build.
  if ((REPEAT_DELAY == 0) && (REPEAT_PERIOD == 0)) begin : g_repeat_unused
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      cnt_q     <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      sync1_q   <= btn_i;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_level_o   = level_q;
  assign btn_press_o   = press_q;
  assign btn_release_o = release_q;

endmodule
